qpsk_tx_sequencer: RTL
======================

Name: qpsk_tx_sequencer

Overview:
- Burst controller for the SSB/QPSK H-bridge modulator.
- Drives the modulator's `stdby`, `set_qpsk` and `qpsk_phase` inputs to send one burst: fixed preamble, byte-stream payload (2 bits/symbol), guard tail, then standby.
- Sits between the PS-side byte FIFO (valid/ready) and the modulator, on the modulator clock domain.

Parameters:
- NBITS, 24, modulator phase precision; `qpsk_phase` width is NBITS+3.
- SYM_W, 16, width of the symbol-period divider.
- PRE_LEN, 16, number of preamble symbols.
- TAIL_LEN, 4, number of guard symbols after payload.

Ports:
- clk  in  1  modulator clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle burst request; honoured only in IDLE.
- abort  in  1  immediate return to IDLE from any state.
- sym_period  in  SYM_W  clocks per symbol; latched at start; 0 is treated as 1.
- s_data  in  8  payload byte; symbols are taken MSB pair first.
- s_valid  in  1  byte valid.
- s_last  in  1  marks the final payload byte.
- s_ready  out  1  byte accepted when `s_valid && s_ready`.
- stdby  out  1  to modulator `stdby`.
- set_qpsk  out  1  to modulator `set_qpsk`.
- qpsk_phase  out  NBITS+3  to modulator `qpsk_phase`.
- busy  out  1  high in any state other than IDLE.
- underflow  out  1  sticky; cleared on start.

Behaviour:
- Reset values (all outputs): `stdby`=1, `set_qpsk`=0, `qpsk_phase`=0, `s_ready`=0, `busy`=0, `underflow`=0. State is IDLE. All outputs are registered.
- Symbol-to-phase map (P = 2^NBITS):
  - sym0 → P
  - sym1 → 2P + P
  - sym2 → 4P + P
  - sym3 → 4P + 2P + P
  - Values are exact; widths are sized so there is no overflow.
- States: IDLE, PRE, DATA, TAIL.
- IDLE:
  - `stdby`=1, `set_qpsk`=0.
  - `start`=1 → PRE on the next edge. The first PRE cycle drives `stdby`=0, `set_qpsk`=1 and phase(sym0).
- Symbol timer: counts 0..sym_period-1. The wrap cycle is the symbol boundary. `qpsk_phase` changes on the edge after the boundary, so each symbol lasts exactly sym_period clocks.
- PRE:
  - Sends alternating sym0, sym2, sym0, ... for PRE_LEN symbols.
  - At the last PRE boundary: go to DATA if the byte buffer is full; otherwise go to TAIL and set `underflow`.
- Byte buffer:
  - One-byte holding register plus a 4-symbol shift register.
  - `s_ready` = (state is PRE or DATA) and holding register empty.
  - The holding register loads on handshake.
  - The shift register loads from the holding register at the boundary where the current byte has finished; the holding register empties on the same edge. A handshake on that same cycle refills it. Simultaneous load and drain is legal.
- DATA:
  - Emits 4 symbols per byte, bits [7:6] first.
  - After the 4th symbol of a byte carrying `s_last` → TAIL.
  - After the 4th symbol with the holding register empty → TAIL and set `underflow`.
- TAIL:
  - Holds the last phase for TAIL_LEN symbols, then → IDLE.
  - Entering IDLE: `stdby`=1 and `set_qpsk`=0 on the same edge; `qpsk_phase` is held.
  - `s_ready`=0 in TAIL.
- abort:
  - Has priority over every other event.
  - Next edge → IDLE with reset output values, except that `underflow` is held.
  - Any buffered bytes are discarded.
- `start` while busy: ignored.
- `start` and `abort` in the same cycle: abort wins, state stays IDLE.
- `rst` asserted mid-burst: all outputs take reset values immediately, without waiting for clk.
- Deassertion of `rst` is expected synchronised externally.

Optional Feature:
- Macro: QPSK_DIFF_EN.
- Defined (differential QPSK):
  - A phase index register (2 bits) is cleared at start.
  - Each symbol does index = index + sym (mod 4); `qpsk_phase` = map(index).
  - Preamble is sent as raw sym2 each symbol, which produces alternating absolute phase.
- Undefined: absolute mapping as above; no index register.

Decomposition:
- Package `qpsk_tx_pkg`:
  - state enum (IDLE/PRE/DATA/TAIL);
  - function mapping a 2-bit symbol to a phase, parameterised by NBITS;
  - preamble symbol constants.
- Sub-module `qpsk_sym_timer`: loadable symbol-period down-counter producing a boundary strobe.

Test Plan:
1. Reset then idle, with NBITS=24, sym_period=4 → `stdby`=1, `set_qpsk`=0, `busy`=0, `s_ready`=0 throughout.
2. start with byte 0x1B (s_last=1) pre-loaded, PRE_LEN=16, TAIL_LEN=4 →
   - 16 PRE symbols alternating 0x1000000 / 0x5000000;
   - DATA phases 0x1000000, 0x3000000, 0x5000000, 0x7000000, each 4 clocks;
   - 16 TAIL clocks at 0x7000000;
   - then `stdby`=1; `underflow`=0.
3. Two bytes 0xFF, 0x00 (s_last on the 2nd), with s_valid toggling every other cycle → continuous 8 data symbols with no gap; exactly 2 handshakes.
4. No byte supplied after PRE → TAIL entered after PRE; `underflow`=1 until the next start.
5. abort asserted in the 3rd data symbol → next edge `stdby`=1, `set_qpsk`=0, `busy`=0; a following start runs a full burst normally.
6. With QPSK_DIFF_EN defined, byte 0x55 (syms 1,1,1,1) → phases map(1), map(2), map(3), map(0) relative to the index after the preamble.

Source files
------------

// File: rtl/qpsk_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : qpsk_tx_pkg                                                 |
// | Description : Shared types and helpers for the QPSK burst sequencer:      |
// |               FSM state encoding, preamble symbols, symbol-to-phase map.  |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
package qpsk_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_TAIL = 2'd3
  } tx_state_e;

  // Absolute preamble alternates these two symbols, starting with the even one.
  localparam logic [1:0] PRE_SYM_EVEN = 2'd0;
  localparam logic [1:0] PRE_SYM_ODD  = 2'd2;
  // Differential preamble: a constant +2 step yields alternating absolute phase.
  localparam logic [1:0] PRE_SYM_DIFF = 2'd2;

  localparam int unsigned PHASE_MAX_W = 64;

  // phase = (2*sym + 1) * 2^nbits, i.e. P, 3P, 5P, 7P. Callers cast down to
  // nbits+3 bits, which always holds 7P exactly.
  function automatic logic [PHASE_MAX_W-1:0] sym_to_phase(input logic [1:0] sym,
                                                          input int unsigned nbits);
    logic [PHASE_MAX_W-1:0] mult;
    mult = {{(PHASE_MAX_W-3){1'b0}}, sym, 1'b1};
    return mult << nbits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qpsk_sym_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : qpsk_sym_timer                                              |
// | Description : Loadable symbol-period down-counter. The period is latched  |
// |               on load (0 treated as 1); while running, boundary is high   |
// |               on the last clock of every symbol.                          |
// | Revision    : 1.0  initial release                                        |
// | Ports       : clk, rst (async, active-low), load, run, period[SYM_W],     |
// |               boundary                                                    |
// +--------------------------------------------------------------------------+
module qpsk_sym_timer #(
  parameter int unsigned SYM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [SYM_W-1:0] period,
  output logic             boundary
);

  logic [SYM_W-1:0] period_q, period_d;
  logic [SYM_W-1:0] cnt_q, cnt_d;

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    if (load) begin
      period_d = (period == '0) ? SYM_W'(1) : period;
      // Count down from period-1 so the first symbol already lasts a full period.
      cnt_d    = period_d - SYM_W'(1);
    end else if (run) begin
      cnt_d = (cnt_q == '0) ? (period_q - SYM_W'(1)) : (cnt_q - SYM_W'(1));
    end
  end

  assign boundary = run && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_q <= SYM_W'(1);
      cnt_q    <= '0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/qpsk_tx_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : qpsk_tx_sequencer                                           |
// | Description : Burst controller for the SSB/QPSK H-bridge modulator.       |
// |               Sends preamble, byte payload (2 bits/symbol, MSB pair       |
// |               first), guard tail, then returns to standby.                |
// | Revision    : 1.0  initial release                                        |
// | Macro       : QPSK_DIFF_EN - differential phase mapping when defined      |
// | Ports       : clk, rst (async, active-low), start, abort,                 |
// |               sym_period[SYM_W], s_data[8]/s_valid/s_last/s_ready (byte   |
// |               stream in), stdby, set_qpsk, qpsk_phase[NBITS+3]            |
// |               (modulator), busy, underflow (sticky, cleared on start)     |
// +--------------------------------------------------------------------------+
module qpsk_tx_sequencer
  import qpsk_tx_pkg::*;
#(
  parameter int unsigned NBITS    = 24,
  parameter int unsigned SYM_W    = 16,
  parameter int unsigned PRE_LEN  = 16,
  parameter int unsigned TAIL_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [SYM_W-1:0]   sym_period,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic               stdby,
  output logic               set_qpsk,
  output logic [NBITS+2:0]   qpsk_phase,
  output logic               busy,
  output logic               underflow
);

  localparam int unsigned PH_W    = NBITS + 3;
  localparam int unsigned CNT_MAX = (PRE_LEN > TAIL_LEN) ? PRE_LEN : TAIL_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 2;

`ifdef QPSK_DIFF_EN
  localparam logic [1:0] PRE_FIRST = PRE_SYM_DIFF;
`else
  localparam logic [1:0] PRE_FIRST = PRE_SYM_EVEN;
`endif

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [7:0]       hold_data_q, hold_data_d;
  logic             hold_last_q, hold_last_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q, shift_d;
  logic             shift_last_q, shift_last_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             s_ready_q, s_ready_d;
  logic             stdby_q, stdby_d;
  logic             set_qpsk_q, set_qpsk_d;
  logic             busy_q, busy_d;
  logic             underflow_q, underflow_d;
`ifdef QPSK_DIFF_EN
  logic [1:0]       idx_q, idx_d;
  logic             emit_clr;
`endif

  logic             emit_en;
  logic [1:0]       emit_sym;
  logic [1:0]       pre_next;
  logic             hs;
  logic             start_go;
  logic             sym_bnd;

  assign hs       = s_valid && s_ready_q;
  assign start_go = start && (state_q == ST_IDLE) && !abort;

`ifdef QPSK_DIFF_EN
  assign pre_next = PRE_SYM_DIFF;
`else
  // Current preamble symbol index even -> next one is odd, and vice versa.
  assign pre_next = sym_cnt_q[0] ? PRE_SYM_EVEN : PRE_SYM_ODD;
`endif

  qpsk_sym_timer #(
    .SYM_W (SYM_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (start_go),
    .run      (busy_q),
    .period   (sym_period),
    .boundary (sym_bnd)
  );

  always_comb begin
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    phase_d      = phase_q;
    underflow_d  = underflow_q;
    emit_en      = 1'b0;
    emit_sym     = 2'd0;
`ifdef QPSK_DIFF_EN
    emit_clr     = 1'b0;
    idx_d        = idx_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_PRE;
          sym_cnt_d   = '0;
          underflow_d = 1'b0;
          hold_full_d = 1'b0;
          emit_en     = 1'b1;
          emit_sym    = PRE_FIRST;
`ifdef QPSK_DIFF_EN
          emit_clr    = 1'b1;
`endif
        end
      end

      ST_PRE: begin
        if (sym_bnd) begin
          if (sym_cnt_q == CNT_W'(PRE_LEN - 1)) begin
            sym_cnt_d = '0;
            if (hold_full_q) begin
              state_d      = ST_DATA;
              shift_d      = hold_data_q;
              shift_last_d = hold_last_q;
              hold_full_d  = 1'b0;
              emit_en      = 1'b1;
              emit_sym     = hold_data_q[7:6];
            end else begin
              state_d     = ST_TAIL;
              underflow_d = 1'b1;
            end
          end else begin
            sym_cnt_d = sym_cnt_q + CNT_W'(1);
            emit_en   = 1'b1;
            emit_sym  = pre_next;
          end
        end
      end

      ST_DATA: begin
        if (sym_bnd) begin
          if (sym_cnt_q == CNT_W'(3)) begin
            sym_cnt_d = '0;
            if (shift_last_q) begin
              state_d = ST_TAIL;
            end else if (hold_full_q) begin
              shift_d      = hold_data_q;
              shift_last_d = hold_last_q;
              hold_full_d  = 1'b0;
              emit_en      = 1'b1;
              emit_sym     = hold_data_q[7:6];
            end else begin
              state_d     = ST_TAIL;
              underflow_d = 1'b1;
            end
          end else begin
            // shift_q[7:6] is the symbol on air; the next pair sits below it.
            sym_cnt_d = sym_cnt_q + CNT_W'(1);
            shift_d   = shift_q << 2;
            emit_en   = 1'b1;
            emit_sym  = shift_q[5:4];
          end
        end
      end

      ST_TAIL: begin
        if (sym_bnd) begin
          if (sym_cnt_q == CNT_W'(TAIL_LEN - 1)) begin
            state_d   = ST_IDLE;
            sym_cnt_d = '0;
          end else begin
            sym_cnt_d = sym_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (emit_en) begin
`ifdef QPSK_DIFF_EN
      idx_d   = (emit_clr ? 2'd0 : idx_q) + emit_sym;
      phase_d = PH_W'(sym_to_phase(idx_d, NBITS));
`else
      phase_d = PH_W'(sym_to_phase(emit_sym, NBITS));
`endif
    end

    // Applied after the drain so a same-edge refill would win over the drain.
    if (hs) begin
      hold_data_d = s_data;
      hold_last_d = s_last;
      hold_full_d = 1'b1;
    end

    if (abort) begin
      state_d     = ST_IDLE;
      sym_cnt_d   = '0;
      phase_d     = '0;
      hold_full_d = 1'b0;
      underflow_d = underflow_q;
`ifdef QPSK_DIFF_EN
      idx_d       = idx_q;
`endif
    end

    busy_d     = (state_d != ST_IDLE);
    stdby_d    = (state_d == ST_IDLE);
    set_qpsk_d = (state_d != ST_IDLE);
    s_ready_d  = ((state_d == ST_PRE) || (state_d == ST_DATA)) && !hold_full_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      sym_cnt_q    <= '0;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      shift_last_q <= 1'b0;
      phase_q      <= '0;
      s_ready_q    <= 1'b0;
      stdby_q      <= 1'b1;
      set_qpsk_q   <= 1'b0;
      busy_q       <= 1'b0;
      underflow_q  <= 1'b0;
`ifdef QPSK_DIFF_EN
      idx_q        <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      phase_q      <= phase_d;
      s_ready_q    <= s_ready_d;
      stdby_q      <= stdby_d;
      set_qpsk_q   <= set_qpsk_d;
      busy_q       <= busy_d;
      underflow_q  <= underflow_d;
`ifdef QPSK_DIFF_EN
      idx_q        <= idx_d;
`endif
    end
  end

  assign s_ready    = s_ready_q;
  assign stdby      = stdby_q;
  assign set_qpsk   = set_qpsk_q;
  assign qpsk_phase = phase_q;
  assign busy       = busy_q;
  assign underflow  = underflow_q;

endmodule
`default_nettype wire
